// File: rtl/operand_bypass_unit_pkg.sv
// Shared types and constants for the operand bypass unit.
package bypass_pkg;

  localparam int unsigned RA_W_DEFAULT = 5;
  localparam int unsigned XLEN_DEFAULT = 32;

  // Architectural zero register; never forwarded.
  localparam logic [RA_W_DEFAULT-1:0] REG_X0 = '0;

  // One in-flight producer, laid out at the default widths. The datapath stores the same
  // fields as per-field vectors so XLEN and RA_W stay overridable.
  typedef struct packed {
    logic                      valid;
    logic [RA_W_DEFAULT-1:0]   rd;
    logic                      is_load;
    logic [XLEN_DEFAULT-1:0]   data;
  } entry_t;

endpackage

// File: rtl/operand_bypass_unit_if.sv
// Producer/consumer bus of the operand bypass unit.
interface operand_bypass_unit_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned RA_W    = bypass_pkg::RA_W_DEFAULT
);

  // Producer leaving EX
  logic                      issue_valid;
  logic                      issue_wen;
  logic                      issue_is_load;
  logic [RA_W-1:0]           issue_rd;
  logic [XLEN-1:0]           ex_result;
  logic [XLEN-1:0]           mem_load_data;
  logic                      flush;

  // Consumer operands
  logic [NUM_SRC*RA_W-1:0]   rs_addr;
  logic [NUM_SRC-1:0]        rs_used;
  logic [NUM_SRC*XLEN-1:0]   rf_data;
  logic [XLEN-1:0]           imm;
  logic [NUM_SRC-1:0]        imm_sel;

  // Results
  logic [NUM_SRC*XLEN-1:0]   opnd;
  logic [NUM_SRC*XLEN-1:0]   fwd;
  logic                      stall;

  modport master (
    output issue_valid, issue_wen, issue_is_load, issue_rd, ex_result, mem_load_data, flush,
    output rs_addr, rs_used, rf_data, imm, imm_sel,
    input  opnd, fwd, stall
  );

  modport slave (
    input  issue_valid, issue_wen, issue_is_load, issue_rd, ex_result, mem_load_data, flush,
    input  rs_addr, rs_used, rf_data, imm, imm_sel,
    output opnd, fwd, stall
  );

endinterface

// File: rtl/operand_bypass_unit_select.sv
// Priority match of one source operand against the in-flight producers.
// Stage index 0 is the youngest producer.
module bypass_select
  import bypass_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned RA_W  = RA_W_DEFAULT
) (
  input  logic [RA_W-1:0]       rs_addr,
  input  logic                  rs_used,
  input  logic [XLEN-1:0]       rf_data,
  input  logic [DEPTH-1:0]      ent_valid,
  input  logic [DEPTH*RA_W-1:0] ent_rd,
  input  logic [DEPTH*XLEN-1:0] ent_data,
  input  logic                  stage1_is_load,
  output logic [XLEN-1:0]       fwd,
  output logic                  hit,
  output logic                  load_hazard
);

  logic [DEPTH-1:0] match;

  // Per-stage match; x0 is excluded so it always reads the register file.
  always_comb begin
    match = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match[k] = rs_used & ent_valid[k] & (ent_rd[k*RA_W +: RA_W] == rs_addr)
                 & (rs_addr != RA_W'(REG_X0));
    end
  end

  // Walk oldest to youngest so the youngest match overrides.
  always_comb begin
    fwd = rf_data;
    hit = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match[k]) begin
        fwd = ent_data[k*XLEN +: XLEN];
        hit = 1'b1;
      end
    end
    // Stage 1 wins whenever it matches, so its load flag decides the hazard.
    load_hazard = match[0] & stage1_is_load;
  end

endmodule

// File: rtl/operand_bypass_unit.sv
// Forwarding/bypass unit: shift-register scoreboard of recent writes, per-operand
// youngest-match selection, immediate select and one-cycle load-use stall.
// Optional macro BYPASS_STATS_EN adds saturating stall/forward event counters.
module operand_bypass_unit
  import bypass_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned RA_W    = RA_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  operand_bypass_unit_if.slave  bus
`ifdef BYPASS_STATS_EN
  ,
  output logic [31:0]           stat_stall_cnt,
  output logic [31:0]           stat_fwd_cnt
`endif
);

  // Scoreboard, one field per vector; index 0 is stage 1.
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH*RA_W-1:0] rd_q, rd_d;
  logic [DEPTH*XLEN-1:0] data_q, data_d;
  // Only stage 1 can hold an unresolved load; it is promoted on the way to stage 2.
  logic                  load_q, load_d;

  logic [NUM_SRC-1:0]      hit;
  logic [NUM_SRC-1:0]      hazard;
  logic [NUM_SRC*XLEN-1:0] fwd_vec;
  logic                    stall;
  logic                    ins_valid;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
    bypass_select #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH),
      .RA_W  (RA_W)
    ) u_select (
      .rs_addr        (bus.rs_addr[i*RA_W +: RA_W]),
      .rs_used        (bus.rs_used[i]),
      .rf_data        (bus.rf_data[i*XLEN +: XLEN]),
      .ent_valid      (valid_q),
      .ent_rd         (rd_q),
      .ent_data       (data_q),
      .stage1_is_load (load_q),
      .fwd            (fwd_vec[i*XLEN +: XLEN]),
      .hit            (hit[i]),
      .load_hazard    (hazard[i])
    );
  end

  // Outputs: stall, store-data path and final operand with immediate select.
  always_comb begin
    stall    = |hazard;
    bus.stall = stall;
    bus.fwd  = fwd_vec;
    bus.opnd = fwd_vec;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.imm_sel[i]) bus.opnd[i*XLEN +: XLEN] = bus.imm;
    end
  end

  // Next scoreboard: insert (or bubble) at stage 1, shift the rest, promote a stage-1 load.
  always_comb begin
    ins_valid = bus.issue_valid & bus.issue_wen & ~stall & ~bus.flush;
    valid_d   = '0;
    rd_d      = '0;
    data_d    = '0;
    valid_d[0]        = ins_valid;
    load_d            = ins_valid & bus.issue_is_load;
    rd_d[0 +: RA_W]   = ins_valid ? bus.issue_rd : '0;
    data_d[0 +: XLEN] = ins_valid ? bus.ex_result : '0;
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k]             = valid_q[k-1];
      rd_d[k*RA_W +: RA_W]   = rd_q[(k-1)*RA_W +: RA_W];
      data_d[k*XLEN +: XLEN] = data_q[(k-1)*XLEN +: XLEN];
      if (k == 1 && load_q) data_d[k*XLEN +: XLEN] = bus.mem_load_data;
    end
  end

  // Scoreboard registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      load_q  <= load_d;
    end
  end

`ifdef BYPASS_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] fwd_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((|hit) && !stall && fwd_cnt_q != 32'hFFFF_FFFF) fwd_cnt_q <= fwd_cnt_q + 32'd1;
    end
  end

  assign stat_stall_cnt = stall_cnt_q;
  assign stat_fwd_cnt   = fwd_cnt_q;
`endif

endmodule
